// File: rtl/mem_io_ctrl_if.sv
// CPU-side request/acknowledge bus of the SLC-3 memory/IO bridge.
// Handshake: the CPU raises Req with We/Addr/Wdata and holds them until Ack pulses for one cycle.
interface mem_io_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              Req;
    logic              We;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Wdata;
    logic [DATA_W-1:0] Rdata;
    logic              Ack;
    logic              Busy;

    modport master (output Req, We, Addr, Wdata, input Rdata, Ack, Busy);
    modport slave  (input Req, We, Addr, Wdata, output Rdata, Ack, Busy);
endinterface

// File: rtl/mem_io_ctrl.sv
// Memory/IO bridge: SRAM accesses with configurable wait states, plus the switch,
// hex-digit and LED registers mapped onto the two topmost addresses.
module mem_io_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1,
    parameter int NUM_HEX     = 4,
    parameter int SW_W        = 10,
    parameter int LED_W       = 10
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    mem_io_ctrl_if.slave         bus,
    input  logic [SW_W-1:0]      SW,
    output logic [LED_W-1:0]     LED,
    output logic [NUM_HEX*4-1:0] Hex,
    output logic [ADDR_W-1:0]    SRAM_Addr,
    output logic [DATA_W-1:0]    SRAM_Wdata,
    input  logic [DATA_W-1:0]    SRAM_Rdata,
    output logic                 SRAM_OE_n,
    output logic                 SRAM_WE_n,
    output logic [1:0]           Dbg_State
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    localparam logic [ADDR_W-1:0] SW_ADDR  = '1;
    localparam logic [ADDR_W-1:0] LED_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};

    state_t               r_state;
    logic                 r_we;
    logic [3:0]           r_cnt;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_rdata;
    logic [NUM_HEX*4-1:0] r_hex;
    logic [LED_W-1:0]     r_led;
    logic                 r_ack;
    logic                 r_busy;
    logic                 r_oe_n;
    logic                 r_we_n;

    logic w_is_sw;
    logic w_is_led;

    assign w_is_sw  = (bus.Addr == SW_ADDR);
    assign w_is_led = (bus.Addr == LED_ADDR);

    // I/O side effects land on the accepting edge, so an I/O access goes straight to DONE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_hex   <= '0;
            r_led   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.Req) begin
                        r_addr  <= bus.Addr;
                        r_wdata <= bus.Wdata;
                        r_we    <= bus.We;
                        r_busy  <= 1'b1;
                        if (w_is_sw || w_is_led) begin
                            r_state <= DONE;
                            r_ack   <= 1'b1;
                            if (bus.We && w_is_sw)   r_hex   <= bus.Wdata[NUM_HEX*4-1:0];
                            if (bus.We && w_is_led)  r_led   <= bus.Wdata[LED_W-1:0];
                            if (!bus.We && w_is_sw)  r_rdata <= DATA_W'(SW);
                            if (!bus.We && w_is_led) r_rdata <= DATA_W'(r_led);
                        end else begin
                            r_state <= ACCESS;
                            r_cnt   <= 4'(WAIT_STATES);
                            r_oe_n  <= bus.We;
                            r_we_n  <= !bus.We;
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_we) r_rdata <= SRAM_Rdata;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Rdata  = r_rdata;
    assign bus.Ack    = r_ack;
    assign bus.Busy   = r_busy;
    assign LED        = r_led;
    assign Hex        = r_hex;
    assign SRAM_Addr  = r_addr;
    assign SRAM_Wdata = r_wdata;
    assign SRAM_OE_n  = r_oe_n;
    assign SRAM_WE_n  = r_we_n;
    assign Dbg_State  = r_state;
endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: directed scenarios plus randomized accesses against a transaction-level model.
module tb_mem_io_ctrl;
    localparam int WS  = 1;
    localparam int WS3 = 3;

    logic        Clk;
    logic        Reset_n;
    logic        rst3_n;
    logic        sel;
    logic        req, we;
    logic [15:0] addr, wdata;
    logic [9:0]  sw;
    logic [15:0] sram_rdata;

    mem_io_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus  ();
    mem_io_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus3 ();

    logic [9:0]  led, led3;
    logic [15:0] hex, hex3;
    logic [15:0] sram_addr, sram_addr3, sram_wdata, sram_wdata3;
    logic        oe_n, oe3_n, we_n, we3_n;
    logic [1:0]  dbg, dbg3;

    assign bus.Req    = req & ~sel;
    assign bus.We     = we;
    assign bus.Addr   = addr;
    assign bus.Wdata  = wdata;
    assign bus3.Req   = req & sel;
    assign bus3.We    = we;
    assign bus3.Addr  = addr;
    assign bus3.Wdata = wdata;

    mem_io_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(WS), .NUM_HEX(4), .SW_W(10), .LED_W(10)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave), .SW(sw), .LED(led), .Hex(hex),
        .SRAM_Addr(sram_addr), .SRAM_Wdata(sram_wdata), .SRAM_Rdata(sram_rdata),
        .SRAM_OE_n(oe_n), .SRAM_WE_n(we_n), .Dbg_State(dbg));

    mem_io_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(WS3), .NUM_HEX(4), .SW_W(10), .LED_W(10)) u_dut3 (
        .Clk(Clk), .Reset_n(rst3_n), .bus(bus3.slave), .SW(sw), .LED(led3), .Hex(hex3),
        .SRAM_Addr(sram_addr3), .SRAM_Wdata(sram_wdata3), .SRAM_Rdata(sram_rdata),
        .SRAM_OE_n(oe3_n), .SRAM_WE_n(we3_n), .Dbg_State(dbg3));

    wire        m_ack   = sel ? bus3.Ack   : bus.Ack;
    wire        m_busy  = sel ? bus3.Busy  : bus.Busy;
    wire [15:0] m_rdata = sel ? bus3.Rdata : bus.Rdata;
    wire        m_oe_n  = sel ? oe3_n      : oe_n;
    wire        m_we_n  = sel ? we3_n      : we_n;
    wire [15:0] m_saddr = sel ? sram_addr3 : sram_addr;
    wire [15:0] m_swd   = sel ? sram_wdata3 : sram_wdata;

    int vectors;
    int miscompares;

    // transaction-level model of the main instance's architectural registers
    logic [15:0] md_rdata;
    logic [15:0] md_hex;
    logic [9:0]  md_led;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One access: drive the request, watch strobes and Ack, drop Req once Ack is seen.
    task automatic run_access(input logic a_we, input logic [15:0] a_addr, input logic [15:0] a_wdata,
                              input bit glitch, output int lat, output int n_oe, output int n_we,
                              output int n_ack, output bit addr_ok, output bit wdata_ok,
                              output logic [15:0] rd, output logic busy_after);
        int  n;
        bit  got;
        @(negedge Clk);
        req = 1'b1; we = a_we; addr = a_addr; wdata = a_wdata;
        lat = -1; n_oe = 0; n_we = 0; n_ack = 0; addr_ok = 1'b1; wdata_ok = 1'b1; rd = 'x;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge Clk);
            n++;
            if (!m_oe_n) n_oe++;
            if (!m_we_n) n_we++;
            if ((!m_oe_n || !m_we_n || m_ack) && m_saddr !== a_addr) addr_ok = 1'b0;
            if (!m_we_n && m_swd !== a_wdata) wdata_ok = 1'b0;
            if (m_ack) begin
                got = 1'b1; lat = n; n_ack++; rd = m_rdata;
                req = 1'b0; addr = 16'h0000;
            end else if (glitch) begin
                req  = 1'($urandom_range(0, 1));
                addr = 16'($urandom);
            end
        end
        req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            if (m_ack) n_ack++;
            if (!m_oe_n) n_oe++;
            if (!m_we_n) n_we++;
        end
        busy_after = m_busy;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; rst3_n = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1; rst3_n = 1'b1;
        repeat (2) @(negedge Clk);
        md_rdata = 16'h0; md_hex = 16'h0; md_led = 10'h0;
        vectors++; if (bus.Rdata !== 16'h0) begin miscompares++; $display("FAIL reset_rdata got=%h exp=0000", bus.Rdata); end
        vectors++; if (hex !== 16'h0) begin miscompares++; $display("FAIL reset_hex got=%h exp=0000", hex); end
        vectors++; if (led !== 10'h0) begin miscompares++; $display("FAIL reset_led got=%h exp=000", led); end
        vectors++; if (bus.Ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got=%b exp=0", bus.Ack); end
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
        vectors++; if (oe_n !== 1'b1 || we_n !== 1'b1) begin miscompares++; $display("FAIL reset_strobes got=%b%b exp=11", oe_n, we_n); end
        vectors++; if (sram_addr !== 16'h0) begin miscompares++; $display("FAIL reset_sram_addr got=%h exp=0000", sram_addr); end
        vectors++; if (sram_wdata !== 16'h0) begin miscompares++; $display("FAIL reset_sram_wdata got=%h exp=0000", sram_wdata); end
    endtask

    task automatic test_sram_read;
        int lat, n_oe, n_we, n_ack; bit a_ok, w_ok; logic [15:0] rd; logic b;
        sram_rdata = 16'h1234;
        run_access(1'b0, 16'h0010, 16'h0000, 1'b0, lat, n_oe, n_we, n_ack, a_ok, w_ok, rd, b);
        md_rdata = 16'h1234;
        vectors++; if (lat !== WS + 2) begin miscompares++; $display("FAIL rd_latency got=%0d exp=%0d", lat, WS + 2); end
        vectors++; if (n_oe !== WS + 1) begin miscompares++; $display("FAIL rd_oe_cycles got=%0d exp=%0d", n_oe, WS + 1); end
        vectors++; if (n_we !== 0) begin miscompares++; $display("FAIL rd_we_cycles got=%0d exp=0", n_we); end
        vectors++; if (n_ack !== 1) begin miscompares++; $display("FAIL rd_ack_count got=%0d exp=1", n_ack); end
        vectors++; if (rd !== 16'h1234) begin miscompares++; $display("FAIL rd_data got=%h exp=1234", rd); end
        vectors++; if (!a_ok) begin miscompares++; $display("FAIL rd_addr_stable got=0 exp=1"); end
        vectors++; if (b !== 1'b0) begin miscompares++; $display("FAIL rd_busy_after got=%b exp=0", b); end
    endtask

    task automatic test_sram_write;
        int lat, n_oe, n_we, n_ack; bit a_ok, w_ok; logic [15:0] rd; logic b;
        sram_rdata = 16'h7777;
        run_access(1'b1, 16'h0020, 16'hBEEF, 1'b0, lat, n_oe, n_we, n_ack, a_ok, w_ok, rd, b);
        vectors++; if (lat !== WS + 2) begin miscompares++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WS + 2); end
        vectors++; if (n_we !== WS + 1) begin miscompares++; $display("FAIL wr_we_cycles got=%0d exp=%0d", n_we, WS + 1); end
        vectors++; if (n_oe !== 0) begin miscompares++; $display("FAIL wr_oe_cycles got=%0d exp=0", n_oe); end
        vectors++; if (!w_ok || !a_ok) begin miscompares++; $display("FAIL wr_bus_stable got=%b%b exp=11", a_ok, w_ok); end
        vectors++; if (n_ack !== 1) begin miscompares++; $display("FAIL wr_ack_count got=%0d exp=1", n_ack); end
        vectors++; if (bus.Rdata !== md_rdata) begin miscompares++; $display("FAIL wr_rdata_kept got=%h exp=%h", bus.Rdata, md_rdata); end
    endtask

    task automatic test_io;
        int lat, n_oe, n_we, n_ack; bit a_ok, w_ok; logic [15:0] rd; logic b;
        logic [15:0] io_addr [3];
        logic        io_we   [3];
        logic [15:0] io_data [3];
        io_addr = '{16'hFFFF, 16'hFFFE, 16'hFFFF};
        io_we   = '{1'b1, 1'b1, 1'b0};
        io_data = '{16'hABCD, 16'h03FF, 16'h0000};
        sw = 10'h155;
        for (int i = 0; i < 3; i++) begin
            run_access(io_we[i], io_addr[i], io_data[i], 1'b0, lat, n_oe, n_we, n_ack, a_ok, w_ok, rd, b);
            vectors++; if (lat !== 1) begin miscompares++; $display("FAIL io%0d_latency got=%0d exp=1", i, lat); end
            vectors++; if (n_oe + n_we !== 0) begin miscompares++; $display("FAIL io%0d_strobes got=%0d exp=0", i, n_oe + n_we); end
            vectors++; if (n_ack !== 1) begin miscompares++; $display("FAIL io%0d_ack_count got=%0d exp=1", i, n_ack); end
        end
        md_hex = 16'hABCD; md_led = 10'h3FF; md_rdata = 16'h0155;
        vectors++; if (hex !== 16'hABCD) begin miscompares++; $display("FAIL io_hex got=%h exp=abcd", hex); end
        vectors++; if (led !== 10'h3FF) begin miscompares++; $display("FAIL io_led got=%h exp=3ff", led); end
        vectors++; if (rd !== 16'h0155) begin miscompares++; $display("FAIL io_sw_read got=%h exp=0155", rd); end
    endtask

    task automatic test_req_during_access;
        int lat, n_oe, n_we, n_ack; bit a_ok, w_ok; logic [15:0] rd; logic b;
        sram_rdata = 16'hC3C3;
        run_access(1'b0, 16'h0030, 16'h0000, 1'b1, lat, n_oe, n_we, n_ack, a_ok, w_ok, rd, b);
        md_rdata = 16'hC3C3;
        vectors++; if (!a_ok) begin miscompares++; $display("FAIL glitch_addr_kept got=0 exp=1"); end
        vectors++; if (n_ack !== 1) begin miscompares++; $display("FAIL glitch_ack_count got=%0d exp=1", n_ack); end
        vectors++; if (lat !== WS + 2) begin miscompares++; $display("FAIL glitch_latency got=%0d exp=%0d", lat, WS + 2); end
        vectors++; if (rd !== 16'hC3C3) begin miscompares++; $display("FAIL glitch_rdata got=%h exp=c3c3", rd); end
    endtask

    task automatic test_reset_mid_access;
        int lat, n_oe, n_we, n_ack, acks; bit a_ok, w_ok; logic [15:0] rd; logic b;
        sel = 1'b1;
        run_access(1'b1, 16'hFFFE, 16'h02A5, 1'b0, lat, n_oe, n_we, n_ack, a_ok, w_ok, rd, b);
        run_access(1'b1, 16'hFFFF, 16'h1234, 1'b0, lat, n_oe, n_we, n_ack, a_ok, w_ok, rd, b);
        vectors++; if (led3 !== 10'h2A5 || hex3 !== 16'h1234) begin miscompares++; $display("FAIL ws3_io_setup got=%h/%h exp=2a5/1234", led3, hex3); end
        sram_rdata = 16'h9999;
        @(negedge Clk);
        req = 1'b1; we = 1'b0; addr = 16'h0040;
        @(negedge Clk);
        vectors++; if (oe3_n !== 1'b0) begin miscompares++; $display("FAIL ws3_strobe_low got=%b exp=0", oe3_n); end
        @(negedge Clk);
        #2 rst3_n = 1'b0;
        #1;
        vectors++; if (oe3_n !== 1'b1 || we3_n !== 1'b1) begin miscompares++; $display("FAIL rst_mid_strobes got=%b%b exp=11", oe3_n, we3_n); end
        vectors++; if (bus3.Busy !== 1'b0 || bus3.Ack !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy_ack got=%b%b exp=00", bus3.Busy, bus3.Ack); end
        vectors++; if (led3 !== 10'h0 || hex3 !== 16'h0) begin miscompares++; $display("FAIL rst_mid_io_clear got=%h/%h exp=000/0000", led3, hex3); end
        req = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (k == 2) rst3_n = 1'b1;
            if (bus3.Ack) acks++;
        end
        vectors++; if (acks !== 0) begin miscompares++; $display("FAIL rst_mid_no_ack got=%0d exp=0", acks); end
        sram_rdata = 16'h5A5A;
        run_access(1'b0, 16'h0050, 16'h0000, 1'b0, lat, n_oe, n_we, n_ack, a_ok, w_ok, rd, b);
        vectors++; if (lat !== WS3 + 2) begin miscompares++; $display("FAIL ws3_latency got=%0d exp=%0d", lat, WS3 + 2); end
        vectors++; if (n_oe !== WS3 + 1) begin miscompares++; $display("FAIL ws3_oe_cycles got=%0d exp=%0d", n_oe, WS3 + 1); end
        vectors++; if (rd !== 16'h5A5A || n_ack !== 1) begin miscompares++; $display("FAIL ws3_read got=%h acks=%0d exp=5a5a acks=1", rd, n_ack); end
        sel = 1'b0;
    endtask

    task automatic test_random;
        int lat, n_oe, n_we, n_ack; bit a_ok, w_ok; logic [15:0] rd; logic b;
        logic [15:0] a, d; logic w; bit g, io;
        int exp_lat, exp_oe, exp_we;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 16'hFFFF;
                1:       a = 16'hFFFE;
                default: a = 16'($urandom_range(0, 16'hFFFD));
            endcase
            w = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            g = 1'($urandom_range(0, 1));
            sw = 10'($urandom_range(0, 1023));
            sram_rdata = 16'($urandom);
            io = (a == 16'hFFFF) || (a == 16'hFFFE);
            exp_lat = io ? 1 : WS + 2;
            exp_oe  = (io || w) ? 0 : WS + 1;
            exp_we  = (io || !w) ? 0 : WS + 1;
            if (!w && a == 16'hFFFF)      md_rdata = {6'b0, sw};
            else if (!w && a == 16'hFFFE) md_rdata = {6'b0, md_led};
            else if (!w)                  md_rdata = sram_rdata;
            else if (a == 16'hFFFF)       md_hex = d;
            else if (a == 16'hFFFE)       md_led = d[9:0];
            run_access(w, a, d, g, lat, n_oe, n_we, n_ack, a_ok, w_ok, rd, b);
            vectors++; if (lat !== exp_lat || n_ack !== 1) begin miscompares++; $display("FAIL rnd%0d_ack got=lat%0d/n%0d exp=lat%0d/n1", i, lat, n_ack, exp_lat); end
            vectors++; if (n_oe !== exp_oe || n_we !== exp_we) begin miscompares++; $display("FAIL rnd%0d_strobes got=oe%0d/we%0d exp=oe%0d/we%0d", i, n_oe, n_we, exp_oe, exp_we); end
            vectors++; if (rd !== md_rdata) begin miscompares++; $display("FAIL rnd%0d_rdata got=%h exp=%h", i, rd, md_rdata); end
            vectors++; if (hex !== md_hex || led !== md_led) begin miscompares++; $display("FAIL rnd%0d_io_regs got=%h/%h exp=%h/%h", i, hex, led, md_hex, md_led); end
            vectors++; if (!a_ok || !w_ok || b !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_bus got=a%b/w%b/busy%b exp=a1/w1/busy0", i, a_ok, w_ok, b); end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        sel = 1'b0; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0;
        sw = 10'h0; sram_rdata = 16'h0;
        Reset_n = 1'b0; rst3_n = 1'b0;
        test_reset();
        test_sram_read();
        test_sram_write();
        test_io();
        test_req_during_access();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Parametrised successor to the SLC-3 memory/IO bridge. It sits between the CPU's MAR/MDR and the external SRAM plus board I/O, and runs every access through a request/acknowledge handshake. SRAM accesses stretch for a configurable number of wait states. Reads of the top address return the switches. Writes to the two top addresses update the hex-digit and LED registers, which are scalable in count and width.

## Interface
Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, address width
- WAIT_STATES, 1, extra SRAM strobe cycles (0..15)
- NUM_HEX, 4, hex digits driven (NUM_HEX*4 <= DATA_W)
- SW_W, 10, switch width (<= DATA_W)
- LED_W, 10, LED width (<= DATA_W)

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Req  in  1  CPU access request, sampled in IDLE
- We  in  1  1 = write, 0 = read; sampled with Req
- Addr  in  ADDR_W  access address (MAR)
- Wdata  in  DATA_W  write data (MDR)
- Rdata  out  DATA_W  read data to MDR, valid while Ack
- Ack  out  1  one-cycle completion pulse
- Busy  out  1  access in progress
- SW  in  SW_W  board switches
- LED  out  LED_W  LED register
- Hex  out  NUM_HEX*4  hex-digit register, digit i = Hex[4i+3:4i]
- SRAM_Addr  out  ADDR_W  latched address
- SRAM_Wdata  out  DATA_W  latched write data
- SRAM_Rdata  in  DATA_W  SRAM read data
- SRAM_OE_n  out  1  SRAM output enable, active low
- SRAM_WE_n  out  1  SRAM write enable, active low

## Operation
- Address map:
  - SW_ADDR = all ones.
  - LED_ADDR = all ones minus 1.
  - Everything else goes to SRAM.
- FSM states: IDLE, ACCESS, DONE.
- IDLE with Req=1:
  - Latch Addr, Wdata and We.
  - If the address is an I/O address, go to DONE. The I/O effect is applied at the same edge:
    - read SW_ADDR: Rdata = zero-extended SW.
    - read LED_ADDR: Rdata = zero-extended LED.
    - write SW_ADDR: Hex = Wdata[NUM_HEX*4-1:0].
    - write LED_ADDR: LED = Wdata[LED_W-1:0].
  - Otherwise load the wait counter with WAIT_STATES and go to ACCESS.
- ACCESS:
  - Strobe: SRAM_OE_n=0 for a read, SRAM_WE_n=0 for a write; the other strobe stays 1.
  - Counter != 0: decrement and stay in ACCESS.
  - Counter == 0: on a read, capture SRAM_Rdata into Rdata. Go to DONE.
- DONE: Ack=1 for exactly one cycle, then IDLE. Req is not sampled in DONE.
- Busy = 1 in ACCESS and DONE.
- An I/O access never asserts an SRAM strobe.
- A write leaves Rdata unchanged.
- Hex, LED and Rdata hold their values until overwritten.
- Req while Busy is ignored, and no request is queued. The CPU must hold Req until it sees Ack; back-to-back requests therefore take at least one IDLE cycle between them.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE.
  - Rdata, Hex and LED = 0.
  - Ack = 0, Busy = 0.
  - SRAM_OE_n = SRAM_WE_n = 1.
  - SRAM_Addr and SRAM_Wdata = 0.
- Reset mid-access: strobes deassert immediately, no Ack is issued, and Hex/LED clear.
- SRAM latency: Req accepted at edge E0 → strobe low for WAIT_STATES+1 cycles → Ack high during the cycle after edge E0+WAIT_STATES+1. That is WAIT_STATES+2 cycles from the Req edge to Ack.
- I/O latency: Ack high during the cycle after E0. Hex/LED update at E0.
- SRAM_Addr and SRAM_Wdata are stable for the whole strobe window. They change only at request acceptance.
- Address compare uses the full ADDR_W bits.

## Test plan
- Reset, then release with no Req → all outputs at their reset values, Busy=0, both strobes high.
- WAIT_STATES=1, read Addr=0x0010 while SRAM_Rdata=0x1234 → SRAM_OE_n low for 2 cycles, Rdata=0x1234, Ack high one cycle 3 cycles after the Req edge, SRAM_WE_n stays high.
- Write Addr=0x0020, Wdata=0xBEEF → SRAM_WE_n low for WAIT_STATES+1 cycles with SRAM_Wdata=0xBEEF throughout, Rdata unchanged, one Ack.
- Write 0xFFFF/0xABCD, then write 0xFFFE/0x03FF, then read 0xFFFF with SW=0x155 → Hex=0xABCD, LED=0x3FF, Rdata=0x0155; each Ack one cycle after its Req edge; no SRAM strobe.
- Toggle Req during ACCESS with a different address → ignored, latched address kept, exactly one Ack.
- Assert Reset_n=0 during a WAIT_STATES=3 read → strobes high at once, no Ack, state IDLE; a new read after release completes normally.
